ifetch_prefetch: RTL and testbench

- Instruction-fetch front end between instruction memory and the pipeline core.
- Speculatively fetches sequential words from the core's requested PC into a DEPTH-entry in-order buffer.
- Presents the instruction matching the core's PC with a valid flag, so the core's fetch stage stalls only on a true miss.
- Any PC discontinuity (branch/jump redirect) flushes the buffer and silently drops stale in-flight responses.

---
 rtl/ifetch_prefetch_if.sv | 23 ++
 rtl/ifetch_prefetch.sv | 95 +++++++++
 tb/tb_ifetch_prefetch.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_prefetch_if.sv
// Fetch-side and memory-side signals of the instruction prefetcher.
// The prefetcher is the master; the core/memory environment is the slave.
interface ifetch_prefetch_if;
  logic [31:0] fetch_pc;
  logic        fetch_take;
  logic [31:0] instr;
  logic        instr_valid;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;

  modport master (
    input  fetch_pc, fetch_take, mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output instr, instr_valid, mem_req_valid, mem_req_addr
  );

  modport slave (
    output fetch_pc, fetch_take, mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  instr, instr_valid, mem_req_valid, mem_req_addr
  );
endinterface

// File: rtl/ifetch_prefetch.sv
// Sequential instruction prefetch buffer: streams words from fetch_pc into an
// in-order FIFO and flushes on any PC discontinuity, discarding stale responses.
module ifetch_prefetch #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic              clk,
  input  logic              rst,
  ifetch_prefetch_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = CW + 2;

  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   head_addr_q, head_addr_d;
  logic [31:0]   next_addr_q, next_addr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;

  logic          mismatch, credit, req_fire, push, drop, pop;
  logic [SW-1:0] used;

  assign mismatch = (bus.fetch_pc != head_addr_q);
  // Every slot is reserved by a buffered word, a live request or a flushed one still owed.
  assign used     = SW'(count_q) + SW'(inflight_q) + SW'(discard_q);
  assign credit   = (used < SW'(DEPTH));

  assign bus.mem_req_valid = !rst && !mismatch && credit;
  assign bus.mem_req_addr  = next_addr_q;
  assign bus.instr_valid   = !rst && (count_q != '0) && !mismatch;
  assign bus.instr         = (count_q != '0) ? mem_q[rd_ptr_q] : 32'h0;

  assign req_fire = bus.mem_req_valid && bus.mem_req_ready;
  assign push     = bus.mem_rsp_valid && !mismatch && (discard_q == '0);
  assign drop     = bus.mem_rsp_valid && !mismatch && (discard_q != '0);
  assign pop      = bus.fetch_take && bus.instr_valid;

  always_comb begin
    head_addr_d = head_addr_q;
    next_addr_d = next_addr_q;
    count_d     = count_q;
    inflight_d  = inflight_q;
    discard_d   = discard_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    if (mismatch) begin
      // Flush: a response landing this cycle belongs to the old stream.
      head_addr_d = bus.fetch_pc;
      next_addr_d = bus.fetch_pc;
      count_d     = '0;
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
      inflight_d  = '0;
      discard_d   = discard_q + inflight_q - CW'(bus.mem_rsp_valid);
    end else begin
      if (req_fire) next_addr_d = next_addr_q + 32'd4;
      inflight_d = inflight_q + CW'(req_fire) - CW'(push);
      discard_d  = discard_q - CW'(drop);
      count_d    = count_q + CW'(push) - CW'(pop);
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop) begin
        rd_ptr_d    = rd_ptr_q + PW'(1);
        head_addr_d = head_addr_q + 32'd4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_addr_q <= RESET_PC;
      next_addr_q <= RESET_PC;
      count_q     <= '0;
      inflight_q  <= '0;
      discard_q   <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
    end else begin
      head_addr_q <= head_addr_d;
      next_addr_q <= next_addr_d;
      count_q     <= count_d;
      inflight_q  <= inflight_d;
      discard_q   <= discard_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.mem_rsp_data;
  end
endmodule

// File: tb/tb_ifetch_prefetch.sv
// Directed bench for ifetch_prefetch against an in-order memory model with
// configurable latency that returns mem[a] = a.
module tb_ifetch_prefetch;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  ifetch_prefetch_if b ();

  ifetch_prefetch #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .bus(b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int lat    = 1;
  int ncyc   = 0;
  logic follow = 1'b0;
  logic [31:0] pend_a [$];
  int          pend_t [$];
  logic [31:0] acc_log [$];

  // Memory: request accepted at edge n is presented from edge n+lat-1 on.
  always @(posedge clk) begin
    ncyc = ncyc + 1;
    if (rst) begin
      pend_a.delete();
      pend_t.delete();
      b.mem_rsp_valid <= 1'b0;
      b.mem_rsp_data  <= 32'h0;
    end else begin
      if (b.mem_req_valid && b.mem_req_ready) begin
        pend_a.push_back(b.mem_req_addr);
        pend_t.push_back(ncyc + lat - 1);
        acc_log.push_back(b.mem_req_addr);
      end
      if (pend_t.size() != 0 && pend_t[0] <= ncyc) begin
        b.mem_rsp_valid <= 1'b1;
        b.mem_rsp_data  <= pend_a[0];
        void'(pend_a.pop_front());
        void'(pend_t.pop_front());
      end else begin
        b.mem_rsp_valid <= 1'b0;
        b.mem_rsp_data  <= 32'h0;
      end
    end
  end

  task automatic tick();
    logic p;
    p = b.fetch_take && b.instr_valid;
    @(posedge clk);
    #2;
    if (p && follow) b.fetch_pc = b.fetch_pc + 32'd4;
    #1;
  endtask

  task automatic restart(input int l, input logic rdy);
    rst = 1'b1; lat = l; follow = 1'b0;
    b.fetch_take = 1'b0; b.mem_req_ready = rdy; b.fetch_pc = 32'h0;
    tick(); tick();
    rst = 1'b0;
    acc_log.delete();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; lat = 1; follow = 1'b1;
    b.fetch_pc = 32'h0; b.fetch_take = 1'b1; b.mem_req_ready = 1'b1;
    tick(); tick();
    checks++; if (b.instr_valid !== 1'b0) begin errors++; $display("FAIL rst_instr_valid: got %b expected 0", b.instr_valid); end
    checks++; if (b.mem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid: got %b expected 0", b.mem_req_valid); end
    checks++; if (b.instr !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h expected 0", b.instr); end
    rst = 1'b0;
    #1;
    checks++; if (b.mem_req_valid !== 1'b1 || b.mem_req_addr !== 32'h0) begin errors++; $display("FAIL first_req: got v=%b a=%h expected v=1 a=0", b.mem_req_valid, b.mem_req_addr); end
    checks++; if (b.instr_valid !== 1'b0) begin errors++; $display("FAIL c0_valid: got %b expected 0", b.instr_valid); end
  endtask

  task automatic test_stream();
    tick();
    checks++; if (b.mem_req_addr !== 32'h4 || b.instr_valid !== 1'b0) begin errors++; $display("FAIL c1: got a=%h v=%b expected a=4 v=0", b.mem_req_addr, b.instr_valid); end
    tick();
    checks++; if (b.instr_valid !== 1'b1 || b.instr !== 32'h0) begin errors++; $display("FAIL c2_first_instr: got v=%b i=%h expected v=1 i=0", b.instr_valid, b.instr); end
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if (b.instr_valid !== 1'b1 || b.instr !== 32'(4 * k)) begin
        errors++; $display("FAIL stream_%0d: got v=%b i=%h expected v=1 i=%h", k, b.instr_valid, b.instr, 32'(4 * k));
      end
    end
  endtask

  task automatic test_redirect_latency();
    b.fetch_pc = 32'h100;
    #1;
    checks++; if (b.instr_valid !== 1'b0 || b.mem_req_valid !== 1'b0) begin errors++; $display("FAIL redir_cycle: got iv=%b rv=%b expected 0 0", b.instr_valid, b.mem_req_valid); end
    tick();
    checks++; if (b.mem_req_valid !== 1'b1 || b.mem_req_addr !== 32'h100) begin errors++; $display("FAIL redir_req: got v=%b a=%h expected v=1 a=100", b.mem_req_valid, b.mem_req_addr); end
    checks++; if (dut.discard_q !== 3'd0 || b.instr_valid !== 1'b0) begin errors++; $display("FAIL redir_t1: got d=%0d iv=%b expected d=0 iv=0", dut.discard_q, b.instr_valid); end
    tick();
    checks++; if (b.instr_valid !== 1'b0) begin errors++; $display("FAIL redir_t2: got %b expected 0", b.instr_valid); end
    tick();
    checks++; if (b.instr_valid !== 1'b1 || b.instr !== 32'h100) begin errors++; $display("FAIL redir_t3: got v=%b i=%h expected v=1 i=100", b.instr_valid, b.instr); end
    tick();
    checks++; if (b.instr_valid !== 1'b1 || b.instr !== 32'h104) begin errors++; $display("FAIL redir_t4: got v=%b i=%h expected v=1 i=104", b.instr_valid, b.instr); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_w [4];
    logic [31:0] seen  [4];
    int got;
    exp_w[0] = 32'hFFFF_FFF8; exp_w[1] = 32'hFFFF_FFFC; exp_w[2] = 32'h0; exp_w[3] = 32'h4;
    got = 0;
    b.fetch_pc = 32'hFFFF_FFF8;
    #1;
    for (int i = 0; i < 12 && got < 4; i++) begin
      if (b.instr_valid) begin seen[got] = b.instr; got++; end
      tick();
    end
    checks++; if (got != 4) begin errors++; $display("FAIL wrap_count: got %0d expected 4", got); end
    for (int i = 0; i < got; i++) begin
      checks++; if (seen[i] !== exp_w[i]) begin errors++; $display("FAIL wrap_%0d: got %h expected %h", i, seen[i], exp_w[i]); end
    end
  endtask

  task automatic test_credit();
    restart(1, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    checks++; if (acc_log.size() != 0) begin errors++; $display("FAIL stall_no_req: got %0d accepted expected 0", acc_log.size()); end
    b.mem_req_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    checks++; if (acc_log.size() != DEPTH) begin errors++; $display("FAIL credit_count: got %0d expected %0d", acc_log.size(), DEPTH); end
    checks++; if (b.mem_req_valid !== 1'b0 || dut.count_q !== 3'd4) begin errors++; $display("FAIL credit_full: got rv=%b cnt=%0d expected 0 4", b.mem_req_valid, dut.count_q); end
    checks++; if (b.instr_valid !== 1'b1 || b.instr !== 32'h0) begin errors++; $display("FAIL full_head: got v=%b i=%h expected 1 0", b.instr_valid, b.instr); end
    b.fetch_take = 1'b1; follow = 1'b1;
    tick();
    b.fetch_take = 1'b0;
    #1;
    checks++; if (b.mem_req_valid !== 1'b1 || b.mem_req_addr !== 32'h10) begin errors++; $display("FAIL credit_return: got v=%b a=%h expected 1 10", b.mem_req_valid, b.mem_req_addr); end
    checks++; if (b.instr_valid !== 1'b1 || b.instr !== 32'h4) begin errors++; $display("FAIL after_pop: got v=%b i=%h expected 1 4", b.instr_valid, b.instr); end
    tick();
    checks++; if (acc_log.size() != 5 || b.mem_req_valid !== 1'b0) begin errors++; $display("FAIL refill: got n=%0d rv=%b expected 5 0", acc_log.size(), b.mem_req_valid); end
  endtask

  task automatic test_redirect_full_and_take_invalid();
    restart(1, 1'b1);
    for (int i = 0; i < 8; i++) tick();
    checks++; if (dut.count_q !== 3'd4) begin errors++; $display("FAIL fill: got %0d expected 4", dut.count_q); end
    b.fetch_pc = 32'h200;
    #1;
    checks++; if (b.instr_valid !== 1'b0 || b.mem_req_valid !== 1'b0) begin errors++; $display("FAIL full_redir: got iv=%b rv=%b expected 0 0", b.instr_valid, b.mem_req_valid); end
    b.mem_req_ready = 1'b0;
    tick();
    checks++; if (dut.count_q !== 3'd0 || dut.head_addr_q !== 32'h200 || dut.discard_q !== 3'd0) begin errors++; $display("FAIL full_flush: got c=%0d h=%h d=%0d expected 0 200 0", dut.count_q, dut.head_addr_q, dut.discard_q); end
    checks++; if (b.mem_req_valid !== 1'b1 || b.mem_req_addr !== 32'h200) begin errors++; $display("FAIL full_newreq: got v=%b a=%h expected 1 200", b.mem_req_valid, b.mem_req_addr); end
    b.fetch_take = 1'b1;
    tick();
    b.fetch_take = 1'b0;
    checks++; if (dut.head_addr_q !== 32'h200 || dut.count_q !== 3'd0 || b.instr_valid !== 1'b0) begin errors++; $display("FAIL take_invalid: got h=%h c=%0d iv=%b expected 200 0 0", dut.head_addr_q, dut.count_q, b.instr_valid); end
  endtask

  task automatic test_double_redirect();
    int idx;
    int nvalid;
    restart(4, 1'b1);
    tick(); tick(); tick();
    checks++; if (dut.inflight_q !== 3'd3 || b.mem_rsp_valid !== 1'b0) begin errors++; $display("FAIL dr_setup: got inf=%0d rsp=%b expected 3 0", dut.inflight_q, b.mem_rsp_valid); end
    b.fetch_pc = 32'h300;
    tick();
    checks++; if (dut.discard_q !== 3'd3 || b.mem_rsp_valid !== 1'b1) begin errors++; $display("FAIL dr_first: got d=%0d rsp=%b expected 3 1", dut.discard_q, b.mem_rsp_valid); end
    idx = acc_log.size();
    b.fetch_pc = 32'h400;
    tick();
    checks++; if (dut.discard_q !== 3'd2 || dut.head_addr_q !== 32'h400) begin errors++; $display("FAIL dr_second: got d=%0d h=%h expected 2 400", dut.discard_q, dut.head_addr_q); end
    b.fetch_take = 1'b1; follow = 1'b1;
    nvalid = 0;
    for (int i = 0; i < 30; i++) begin
      checks++;
      if (dut.count_q + dut.inflight_q + dut.discard_q > DEPTH) begin errors++; $display("FAIL dr_credit_%0d: got %0d expected <= %0d", i, dut.count_q + dut.inflight_q + dut.discard_q, DEPTH); end
      if (b.instr_valid) begin
        nvalid++;
        checks++; if (b.instr !== b.fetch_pc) begin errors++; $display("FAIL dr_stale_%0d: got %h expected %h", i, b.instr, b.fetch_pc); end
      end
      tick();
    end
    checks++; if (dut.discard_q !== 3'd0 || nvalid == 0) begin errors++; $display("FAIL dr_drain: got d=%0d nvalid=%0d expected 0 >0", dut.discard_q, nvalid); end
    checks++; if (acc_log.size() <= idx || acc_log[idx] !== 32'h400) begin errors++; $display("FAIL dr_newaddr: got n=%0d expected first new addr 400", acc_log.size()); end
    b.fetch_take = 1'b0; follow = 1'b0;
  endtask

  task automatic test_reset_mid();
    restart(1, 1'b1);
    b.fetch_pc = 32'h500;
    #1;
    checks++; if (b.mem_req_valid !== 1'b0) begin errors++; $display("FAIL empty_redir: got %b expected 0", b.mem_req_valid); end
    tick();
    checks++; if (b.mem_req_valid !== 1'b1 || b.mem_req_addr !== 32'h500) begin errors++; $display("FAIL empty_redir_req: got v=%b a=%h expected 1 500", b.mem_req_valid, b.mem_req_addr); end
    tick(); tick(); tick(); tick();
    checks++; if (dut.count_q !== 3'd3 || dut.inflight_q !== 3'd1) begin errors++; $display("FAIL mid_setup: got c=%0d inf=%0d expected 3 1", dut.count_q, dut.inflight_q); end
    rst = 1'b1; b.fetch_pc = 32'h0;
    tick();
    checks++; if (dut.count_q !== 3'd0 || dut.inflight_q !== 3'd0 || dut.discard_q !== 3'd0) begin errors++; $display("FAIL mid_rst_ctr: got c=%0d i=%0d d=%0d expected 0 0 0", dut.count_q, dut.inflight_q, dut.discard_q); end
    checks++; if (dut.head_addr_q !== 32'h0 || b.instr_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_head: got h=%h iv=%b expected 0 0", dut.head_addr_q, b.instr_valid); end
    rst = 1'b0;
    #1;
    checks++; if (b.mem_req_valid !== 1'b1 || b.mem_req_addr !== 32'h0) begin errors++; $display("FAIL mid_restart_req: got v=%b a=%h expected 1 0", b.mem_req_valid, b.mem_req_addr); end
    tick(); tick();
    checks++; if (b.instr_valid !== 1'b1 || b.instr !== 32'h0) begin errors++; $display("FAIL mid_restart_instr: got v=%b i=%h expected 1 0", b.instr_valid, b.instr); end
  endtask

  initial begin
    b.fetch_pc = 32'h0; b.fetch_take = 1'b0; b.mem_req_ready = 1'b0;
    test_reset();
    test_stream();
    test_redirect_latency();
    test_wrap();
    test_credit();
    test_redirect_full_and_take_invalid();
    test_double_redirect();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
